if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
- Parametrised successor to the single-entry instruction fetch stage.
- Issues pipelined Avalon-MM reads on the instruction bus and honours waitrequest and readdatavalid.
- Tracks up to MAX_OUTSTANDING in-flight reads and buffers returned instructions with their PCs in a FIFO_DEPTH-entry prefetch queue.
- Sits between the instruction bus and the ID stage. Branch and trap redirects flush the queue and discard stale in-flight responses.

Parameters:
- XLEN, 32, width of PC and instruction word.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, >= 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned reads; 1..FIFO_DEPTH.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- ibus_read  out  1  Avalon read request.
- ibus_address  out  XLEN  Avalon byte address, always 4-aligned.
- ibus_byte_enable  out  4  constant 4'b1111.
- ibus_waitrequest  in  1  slave not accepting; request must be held.
- ibus_readdatavalid  in  1  read data returned this cycle, in order.
- ibus_readdata  in  XLEN  returned instruction.
- branch_take  in  1  branch redirect.
- branch_pc  in  XLEN  branch target.
- trap_take  in  1  trap redirect.
- trap_pc  in  XLEN  trap target.
- if_stall  in  1  ID not accepting.
- if_valid  out  1  queue head valid.
- if_pc  out  XLEN  PC of head.
- if_instruction  out  XLEN  instruction of head.

Behaviour:
- Reset: ibus_read=0, fetch_pc=RESET_PC, outstanding=0, discard=0, queue empty, if_valid=0. All are async-cleared.
- Issue condition: ibus_read=1 when outstanding + queue_count < FIFO_DEPTH, outstanding < MAX_OUTSTANDING, and no held request is pending redirect.
- Acceptance: a read is accepted when ibus_read & !ibus_waitrequest.
  - On acceptance: fetch_pc += 4 and the PC is pushed to the in-flight PC queue.
- Held request: while ibus_waitrequest=1, ibus_read and ibus_address stay stable.
- Response: on readdatavalid with discard=0, push {pc, readdata} into the queue. With discard>0, drop the data and decrement discard.
- Counters: outstanding += accept, -= readdatavalid. Both may occur in the same cycle, giving a net of 0.
- Output: first-word fall-through. if_valid = !queue_empty. Pop when if_valid & !if_stall.
- Latency: with a zero-wait slave, first request issues in cycle 1 after reset release, data returns in cycle 2, and if_valid=1 in cycle 3.
- Sustained throughput is 1 instruction/cycle when MAX_OUTSTANDING>=2.
- Redirect (trap_take | branch_take): trap wins if both are asserted. In the redirect cycle:
  - the queue is flushed;
  - no pop is counted;
  - fetch_pc is set to the target.
  - discard = outstanding after this cycle's accept and return updates, so an accept in the redirect cycle is counted and discarded.
  - readdatavalid in the redirect cycle is dropped.
- Redirect while a request is held by waitrequest: address stays held (Avalon rule). The request is marked for discard and fetch_pc switches to the target once it is accepted.
  - FSM states: RUN (normal), HOLD_REDIR (held request awaiting accept). HOLD_REDIR -> RUN on accept.
  - A second redirect while in HOLD_REDIR only updates the target.
- Stall: if_stall does not stop fetching. The queue fills and then the issue condition deasserts ibus_read.
- Full/empty: no push is ever attempted when the queue is full, by construction of the issue condition. An assertion must check this.
- Arithmetic: fetch_pc addition wraps modulo 2^XLEN. Counters are clog2(FIFO_DEPTH+1) bits wide.

Decomposition:
- Shared package (core.svh): avalon_req_t and avalon_resp_t, plus an if2id_pipeline type for the {valid, pc, instruction} output.
- One generic sub-module, sync_fifo (params WIDTH, DEPTH; async active-low reset; flush input). Instantiated twice:
  - in-flight PC queue, depth MAX_OUTSTANDING;
  - prefetch queue, width 2*XLEN.

Test Plan:
- Zero-wait slave, no stall, RESET_PC=0x0 -> if_pc sequence 0x0, 0x4, 0x8, ... with one instruction/cycle from cycle 3; outstanding never exceeds 2.
- if_stall held 10 cycles -> queue holds 4 entries, ibus_read=0 while full; on release, 4 back-to-back pops with correct pc/instruction pairing.
- Branch to 0x100 while 2 reads are outstanding and 3 entries are queued:
  - both stale responses are dropped and the queue is empty;
  - next if_pc = 0x100.
- trap_take (trap_pc=0x80) and branch_take (branch_pc=0x200) in the same cycle -> next delivered if_pc = 0x80.
- waitrequest held 3 cycles on address 0x10 while branch_take to 0x40 occurs:
  - address stays 0x10 until accepted and its data is discarded;
  - next request address = 0x40.
- Random waitrequest / readdatavalid latency (1-5 cycles) over 1000 cycles against a reference PC model, with random redirects:
  - delivered pc/instruction stream matches the model exactly;
  - no overflow assertion fires.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction prefetch stage.
package if_prefetch_pkg;

  // Fetch control: normal streaming, or a redirect parked behind a held bus request.
  typedef enum logic [0:0] {
    StRun,
    StHoldRedir
  } fetch_state_e;

  // Instruction fetches are always full words.
  localparam logic [3:0] IbusByteEnAll = 4'b1111;

  // Byte distance between consecutive instructions.
  localparam int unsigned PcStep = 4;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_prefetch_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read and a flush input.
module if_prefetch_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [CntW-1:0] cnt_t;

  localparam ptr_t LastPtr  = ptr_t'(DEPTH - 1);
  localparam cnt_t DepthCnt = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + ptr_t'(1);
  endfunction

  // Pointer and occupancy update; flush discards everything.
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + cnt_t'(do_push) - cnt_t'(do_pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Head and status outputs.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
    empty_o = (count_q == '0);
    full_o  = (count_q == DepthCnt);
    count_o = count_q;
  end

  // Writers must never push into a full queue.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && !flush_i && full_o));

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch stage: pipelined Avalon-MM fetch with an in-order prefetch queue.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ibus_read,
  output logic [XLEN-1:0] ibus_address,
  output logic [3:0]      ibus_byte_enable,
  input  logic            ibus_waitrequest,
  input  logic            ibus_readdatavalid,
  input  logic [XLEN-1:0] ibus_readdata,
  input  logic            branch_take,
  input  logic [XLEN-1:0] branch_pc,
  input  logic            trap_take,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            if_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instruction
);

  localparam int unsigned CntW   = cnt_width(FIFO_DEPTH);
  localparam int unsigned FlCntW = cnt_width(MAX_OUTSTANDING);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [CntW:0]   sum_t;

  localparam sum_t DepthLim = sum_t'(FIFO_DEPTH);
  localparam cnt_t MaxOut   = cnt_t'(MAX_OUTSTANDING);

  typedef struct packed {
    logic            read;
    logic [XLEN-1:0] address;
    logic [3:0]      byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic            waitrequest;
    logic            readdatavalid;
    logic [XLEN-1:0] readdata;
  } avalon_resp_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instruction;
  } if2id_pipeline_t;

  avalon_req_t     req;
  avalon_resp_t    resp;
  if2id_pipeline_t if2id;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  cnt_t            outstanding_q, outstanding_d;
  cnt_t            discard_q, discard_d;

  logic            redirect;
  logic [XLEN-1:0] redir_target;
  logic            issue_ok;
  logic            accept;
  logic            held;
  logic            rvalid;

  logic              pf_push, pf_pop, pf_empty, pf_full;
  logic [2*XLEN-1:0] pf_rdata;
  cnt_t              pf_count;

  logic              fl_empty, fl_full;
  logic [XLEN-1:0]   fl_rdata;
  logic [FlCntW-1:0] fl_count;

  // Bus bundle and redirect decode; trap has priority over branch.
  always_comb begin
    resp.waitrequest   = ibus_waitrequest;
    resp.readdatavalid = ibus_readdatavalid;
    resp.readdata      = ibus_readdata;
    redirect           = trap_take | branch_take;
    redir_target       = trap_take ? trap_pc : branch_pc;
    rvalid             = resp.readdatavalid;
    // Every accepted read reserves a queue slot, so responses can never overflow it.
    issue_ok = (({1'b0, outstanding_q} + {1'b0, pf_count}) < DepthLim) &&
               (outstanding_q < MaxOut);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a redirect that meets a stalled request must wait for its acceptance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:       if (redirect && held) state_d = StHoldRedir;
      StHoldRedir: if (accept) state_d = StRun;
      default:     state_d = StRun;
    endcase
  end

  // FSM outputs: a held request stays asserted regardless of queue room.
  always_comb begin
    req.read        = rst_n && ((state_q == StHoldRedir) || issue_ok);
    req.address     = fetch_pc_q;
    req.byte_enable = IbusByteEnAll;
    accept          = req.read && !resp.waitrequest;
    held            = req.read && resp.waitrequest;
  end

  // Fetch PC, pending target and in-flight bookkeeping.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    redir_pc_d    = redir_pc_q;
    outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(rvalid);
    discard_d     = discard_q;
    if (rvalid && (discard_q != '0)) begin
      discard_d = discard_q - cnt_t'(1);
    end
    if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(PcStep);
    end
    if (state_q == StHoldRedir) begin
      if (redirect) begin
        redir_pc_d = redir_target;
      end
      // The held read belongs to the old stream: drop its data and jump once it is taken.
      if (accept) begin
        fetch_pc_d = redirect ? redir_target : redir_pc_q;
        discard_d  = discard_d + cnt_t'(1);
      end
    end else if (redirect) begin
      // Everything still in flight after this cycle is stale.
      discard_d = outstanding_d;
      if (held) begin
        redir_pc_d = redir_target;
      end else begin
        fetch_pc_d = redir_target;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      redir_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      redir_pc_q    <= redir_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // Queue control: a redirect flushes, blocks the pop and drops this cycle's return.
  always_comb begin
    pf_push = rvalid && (discard_q == '0) && !redirect;
    pf_pop  = !pf_empty && !if_stall && !redirect;
  end

  // PCs of accepted reads, matched in order against returned data.
  if_prefetch_sync_fifo #(
    .WIDTH(XLEN),
    .DEPTH(MAX_OUTSTANDING)
  ) u_inflight_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(1'b0),
    .push_i (accept),
    .wdata_i(fetch_pc_q),
    .pop_i  (rvalid),
    .rdata_o(fl_rdata),
    .empty_o(fl_empty),
    .full_o (fl_full),
    .count_o(fl_count)
  );

  // Prefetch queue of {pc, instruction}.
  if_prefetch_sync_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_prefetch_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(redirect),
    .push_i (pf_push),
    .wdata_i({fl_rdata, resp.readdata}),
    .pop_i  (pf_pop),
    .rdata_o(pf_rdata),
    .empty_o(pf_empty),
    .full_o (pf_full),
    .count_o(pf_count)
  );

  // Output ports.
  always_comb begin
    if2id.valid       = !pf_empty;
    if2id.pc          = pf_rdata[2*XLEN-1:XLEN];
    if2id.instruction = pf_rdata[XLEN-1:0];
    if_valid          = if2id.valid;
    if_pc             = if2id.pc;
    if_instruction    = if2id.instruction;
    ibus_read         = req.read;
    ibus_address      = req.address;
    ibus_byte_enable  = req.byte_enable;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(pf_push && pf_full));
  assert property (@(posedge clk) disable iff (!rst_n) !(accept && fl_full));
  assert property (@(posedge clk) disable iff (!rst_n) !(rvalid && fl_empty));
  assert property (@(posedge clk) disable iff (!rst_n) outstanding_q == cnt_t'(fl_count));

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: Avalon slave model plus PC-stream scoreboard.
module tb_if_prefetch;

  localparam int unsigned MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_read;
  logic [31:0] ibus_address;
  logic [3:0]  ibus_byte_enable;
  logic        ibus_waitrequest = 1'b0;
  logic        ibus_readdatavalid = 1'b0;
  logic [31:0] ibus_readdata = '0;
  logic        branch_take = 1'b0;
  logic [31:0] branch_pc = '0;
  logic        trap_take = 1'b0;
  logic [31:0] trap_pc = '0;
  logic        if_stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;

  always #5 clk = ~clk;

  if_prefetch #(
    .XLEN           (32),
    .FIFO_DEPTH     (4),
    .MAX_OUTSTANDING(2),
    .RESET_PC       (32'h0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ibus_read         (ibus_read),
    .ibus_address      (ibus_address),
    .ibus_byte_enable  (ibus_byte_enable),
    .ibus_waitrequest  (ibus_waitrequest),
    .ibus_readdatavalid(ibus_readdatavalid),
    .ibus_readdata     (ibus_readdata),
    .branch_take       (branch_take),
    .branch_pc         (branch_pc),
    .trap_take         (trap_take),
    .trap_pc           (trap_pc),
    .if_stall          (if_stall),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_instruction    (if_instruction)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = '0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_pct = 0, lat_min = 1, lat_max = 1, stall_pct = 0, redir_pct = 0;
  bit          force_wait = 0, stall = 0, want_first = 0;
  bit          prev_held = 0;
  logic [31:0] prev_addr = '0, last_acc_addr = '0, first_pc = '0;
  int          dlv = 0, first_dlv = 0, first_acc = 0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
  endfunction

  function automatic void model_redirect(input logic [31:0] target);
    exp_q.delete();
    model_pc = target;
    top_up();
  endfunction

  // One bus cycle: drive at posedge+1, check and record at negedge, return at posedge+1.
  task automatic step(input bit br, input bit tr, input logic [31:0] bpc, input logic [31:0] tpc);
    bit          rd_v, acc_now, dlv_now, redir, b, t;
    logic [31:0] bp, tp, tgt;
    b = br; t = tr; bp = bpc; tp = tpc;
    if (redir_pct != 0 && int'($urandom_range(99)) < redir_pct) begin
      b  = 1'($urandom_range(1));
      t  = !b || 1'($urandom_range(1));
      bp = $urandom & 32'hFFFF_FFFC;
      tp = $urandom & 32'hFFFF_FFFC;
    end
    ibus_waitrequest = force_wait || (int'($urandom_range(99)) < wr_pct);
    rd_v = (pend.size() > 0) && (pend[0].due <= cyc);
    ibus_readdatavalid = rd_v;
    if (rd_v) begin
      ibus_readdata = instr_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      ibus_readdata = $urandom;
    end
    branch_take = b; trap_take = t; branch_pc = bp; trap_pc = tp;
    if_stall = stall || (stall_pct != 0 && int'($urandom_range(99)) < stall_pct);
    redir = b || t;
    tgt = t ? tp : bp;
    @(negedge clk);
    if (prev_held) begin
      check_eq("held_read", 32'(ibus_read), 32'd1);
      check_eq("held_addr", ibus_address, prev_addr);
    end
    acc_now = ibus_read && !ibus_waitrequest;
    dlv_now = if_valid && !if_stall && !redir;
    if (dlv_now) begin
      top_up();
      check_eq("dlv_pc", if_pc, exp_q[0]);
      check_eq("dlv_instr", if_instruction, instr_of(exp_q[0]));
      void'(exp_q.pop_front());
      dlv++;
      if (first_dlv == 0) first_dlv = cyc;
      if (want_first) begin
        first_pc = if_pc;
        want_first = 0;
      end
    end
    if (redir) model_redirect(tgt);
    if (acc_now) begin
      check_eq("addr_align", ibus_address & 32'd3, 32'd0);
      pend.push_back('{ibus_address, cyc + int'($urandom_range(lat_max, lat_min))});
      last_acc_addr = ibus_address;
      if (first_acc == 0) first_acc = cyc;
    end
    check_eq("max_out", 32'(pend.size() <= MaxOut), 32'd1);
    prev_held = ibus_read && ibus_waitrequest;
    prev_addr = ibus_address;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  d0;
    bit  found;
    model_redirect(32'h0);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_read", 32'(ibus_read), 32'd0);
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("byte_en", 32'(ibus_byte_enable), 32'hF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 1;

    // Zero-wait streaming from RESET_PC.
    idle(20);
    check_eq("first_acc_cyc", first_acc, 1);
    check_eq("first_dlv_cyc", first_dlv, 3);
    check_eq("stream_rate", dlv, 18);

    // Stall fills the queue and stops issuing.
    stall = 1;
    idle(10);
    check_eq("full_read", 32'(ibus_read), 32'd0);
    check_eq("full_valid", 32'(if_valid), 32'd1);
    check_eq("full_outst", pend.size(), 32'd0);
    force_wait = 1;
    stall = 0;
    d0 = dlv;
    idle(4);
    check_eq("drain_4", dlv - d0, 32'd4);
    idle(2);
    check_eq("drain_only_4", dlv - d0, 32'd4);

    // Branch with reads in flight and entries queued.
    force_wait = 0;
    lat_min = 3; lat_max = 3;
    stall = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      if (pend.size() == 2 && if_valid) found = 1;
    end
    check_eq("br_setup", 32'(found), 32'd1);
    stall = 0;
    step(1'b1, 1'b0, 32'h100, 32'h0);
    check_eq("br_flush", 32'(if_valid), 32'd0);
    want_first = 1;
    lat_min = 1; lat_max = 1;
    idle(12);
    check_eq("br_first_pc", first_pc, 32'h100);

    // Trap wins over a simultaneous branch.
    step(1'b1, 1'b1, 32'h200, 32'h80);
    want_first = 1;
    idle(10);
    check_eq("trap_first_pc", first_pc, 32'h80);

    // Redirect while a request is held by waitrequest.
    step(1'b1, 1'b0, 32'h10, 32'h0);
    force_wait = 1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      if (ibus_read && ibus_address == 32'h10) found = 1;
    end
    check_eq("hold_setup", 32'(found), 32'd1);
    step(1'b1, 1'b0, 32'h40, 32'h0);
    check_eq("hold_addr_1", ibus_address, 32'h10);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("hold_addr_2", ibus_address, 32'h10);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("hold_addr_3", ibus_address, 32'h10);
    check_eq("hold_read_3", 32'(ibus_read), 32'd1);
    force_wait = 0;
    step(1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("hold_accept", last_acc_addr, 32'h10);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ibus_read) found = 1;
      else step(1'b0, 1'b0, 32'h0, 32'h0);
    end
    check_eq("post_hold_req", 32'(found), 32'd1);
    check_eq("post_hold_addr", ibus_address, 32'h40);
    want_first = 1;
    idle(10);
    check_eq("hold_first_pc", first_pc, 32'h40);

    // Random waitrequest, latency, stalls and redirects.
    wr_pct = 30; lat_min = 1; lat_max = 5; stall_pct = 20; redir_pct = 3;
    d0 = dlv;
    idle(1000);
    check_eq("rand_progress", 32'((dlv - d0) > 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
